// File: rtl/key_debouncer_pkg.sv
// Shared digital-lock constants and small key-vector helpers.
package key_debouncer_pkg;

  // System clock frequency of the digital lock, in Hz.
  localparam int LOCK_CLOCK_FREQ = 50_000_000;

  // Number of push buttons on the keypad.
  localparam int KEY_W = 4;

  // True when exactly one button is pressed.
  function automatic logic is_one_hot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
  endfunction

  // True when two or more buttons are pressed at once.
  function automatic logic is_multi(input logic [KEY_W-1:0] v);
    return (v != '0) && !is_one_hot(v);
  endfunction

endpackage

// File: rtl/key_debouncer_sync.sv
// Two-flop synchroniser for the asynchronous active-low buttons.
// The output is inverted so downstream logic sees pressed = 1.
module key_synchroniser
  import key_debouncer_pkg::*;
#(
  parameter int W = KEY_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] i_async_n,
  output logic [W-1:0] o_sync
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Two-stage capture; reset loads the released (all-ones) level.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_async_n;
      r_sync <= r_meta;
    end
  end

  assign o_sync = ~r_sync;

endmodule

// File: rtl/key_debouncer.sv
// Keypad debouncer: reports a single debounced one-hot key per press,
// a one-cycle keyPressed strobe, and a multiKey flag for chorded presses.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int CLOCK_FREQ             = LOCK_CLOCK_FREQ,
  parameter int DEBOUNCE_CYCLES        = CLOCK_FREQ / 50,
  parameter int DEBOUNCE_COUNTER_WIDTH = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [KEY_W-1:0] rawKeys,
  output logic [KEY_W-1:0] key,
  output logic             keyPressed,
  output logic             multiKey
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [DEBOUNCE_COUNTER_WIDTH-1:0] CNT_LAST =
    DEBOUNCE_COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEBOUNCE_COUNTER_WIDTH-1:0] CNT_ONE =
    DEBOUNCE_COUNTER_WIDTH'(1);

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [DEBOUNCE_COUNTER_WIDTH-1:0] r_cnt;
  logic [DEBOUNCE_COUNTER_WIDTH-1:0] w_cnt_nxt;
  logic [KEY_W-1:0]                  r_cand;
  logic [KEY_W-1:0]                  w_cand_nxt;
  logic [KEY_W-1:0]                  w_key_nxt;
  logic                              w_kp_nxt;
  logic                              w_mk_nxt;
  logic [KEY_W-1:0]                  w_sync_keys;

  key_synchroniser #(.W(KEY_W)) u_sync (
    .clock     (clock),
    .reset     (reset),
    .i_async_n (rawKeys),
    .o_sync    (w_sync_keys)
  );

  // Next-state and registered-output logic for the debounce FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_key_nxt   = key;
    w_kp_nxt    = 1'b0;
    w_mk_nxt    = multiKey;
    if (w_sync_keys == '0) w_mk_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_key_nxt = '0;
        if (is_one_hot(w_sync_keys)) begin
          w_cand_nxt  = w_sync_keys;
          w_cnt_nxt   = '0;
          w_state_nxt = PRESS_WAIT;
        end else if (is_multi(w_sync_keys)) begin
          w_mk_nxt = 1'b1;
        end
      end
      PRESS_WAIT: begin
        if (w_sync_keys != r_cand) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_key_nxt   = r_cand;
          w_kp_nxt    = 1'b1;
          w_state_nxt = HELD;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      HELD: begin
        w_key_nxt = r_cand;
        if (w_sync_keys != r_cand) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        w_key_nxt = r_cand;
        if (w_sync_keys == r_cand) begin
          w_state_nxt = HELD;
        end else if (w_sync_keys == '0) begin
          if (r_cnt == CNT_LAST) begin
            w_key_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end else begin
          // A different key is down: hold off until everything is released.
          w_cnt_nxt = '0;
        end
      end
      default: begin
        w_key_nxt   = '0;
        w_cnt_nxt   = '0;
        w_cand_nxt  = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, counter, candidate and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cand     <= '0;
      key        <= '0;
      keyPressed <= 1'b0;
      multiKey   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cand     <= w_cand_nxt;
      key        <= w_key_nxt;
      keyPressed <= w_kp_nxt;
      multiKey   <= w_mk_nxt;
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with a 4-cycle debounce window.
module tb_key_debouncer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] rawKeys;
  logic [3:0] key;
  logic       keyPressed;
  logic       multiKey;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] REL = 4'b1111;
  localparam logic [3:0] K0  = 4'b0001;
  localparam logic [3:0] K2  = 4'b0100;
  localparam logic [3:0] NK  = 4'b0000;

  key_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .rawKeys    (rawKeys),
    .key        (key),
    .keyPressed (keyPressed),
    .multiKey   (multiKey)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] k,
                            input logic kp, input logic mk);
    checks++;
    assert ({key, keyPressed, multiKey} === {k, kp, mk}) else begin
      errors++;
      $error("FAIL %s: key=%b keyPressed=%b multiKey=%b, expected key=%b keyPressed=%b multiKey=%b",
             tag, key, keyPressed, multiKey, k, kp, mk);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] k,
                      input logic kp, input logic mk);
    tick();
    expect_out(tag, k, kp, mk);
  endtask

  task automatic steps(input int n, input string tag, input logic [3:0] k,
                       input logic kp, input logic mk);
    for (int i = 0; i < n; i++) step(tag, k, kp, mk);
  endtask

  initial begin
    reset   = 1'b1;
    rawKeys = REL;
    repeat (3) tick();
    expect_out("reset_state", NK, 1'b0, 1'b0);
    reset = 1'b0;
    steps(2, "idle_after_reset", NK, 1'b0, 1'b0);

    // Clean press and hold of key0, then clean release.
    rawKeys = 4'b1110;
    steps(6, "press_wait", NK, 1'b0, 1'b0);
    step("press_key", K0, 1'b1, 1'b0);
    step("press_pulse_end", K0, 1'b0, 1'b0);
    steps(4, "held", K0, 1'b0, 1'b0);
    rawKeys = REL;
    steps(6, "release_wait", K0, 1'b0, 1'b0);
    step("release_done", NK, 1'b0, 1'b0);
    steps(3, "idle", NK, 1'b0, 1'b0);

    // Bouncing press, then stable.
    for (int b = 0; b < 3; b++) begin
      rawKeys = 4'b1110;
      steps(2, "bounce_down", NK, 1'b0, 1'b0);
      rawKeys = REL;
      steps(2, "bounce_up", NK, 1'b0, 1'b0);
    end
    rawKeys = 4'b1110;
    steps(6, "bounce_settle", NK, 1'b0, 1'b0);
    step("bounce_key", K0, 1'b1, 1'b0);
    steps(3, "bounce_held", K0, 1'b0, 1'b0);
    rawKeys = REL;
    steps(6, "bounce_release_wait", K0, 1'b0, 1'b0);
    step("bounce_release_done", NK, 1'b0, 1'b0);
    steps(2, "idle", NK, 1'b0, 1'b0);

    // Release with a one-cycle re-press glitch.
    rawKeys = 4'b1110;
    steps(6, "glitch_press_wait", NK, 1'b0, 1'b0);
    step("glitch_press_key", K0, 1'b1, 1'b0);
    steps(3, "glitch_held", K0, 1'b0, 1'b0);
    rawKeys = REL;
    steps(2, "glitch_release", K0, 1'b0, 1'b0);
    rawKeys = 4'b1110;
    step("glitch_repress", K0, 1'b0, 1'b0);
    rawKeys = REL;
    steps(6, "glitch_release_wait", K0, 1'b0, 1'b0);
    step("glitch_release_done", NK, 1'b0, 1'b0);
    steps(2, "idle", NK, 1'b0, 1'b0);

    // Two buttons from idle.
    rawKeys = 4'b1100;
    steps(2, "multi_sync", NK, 1'b0, 1'b0);
    steps(5, "multi_set", NK, 1'b0, 1'b1);
    rawKeys = REL;
    steps(2, "multi_release_sync", NK, 1'b0, 1'b1);
    step("multi_clear", NK, 1'b0, 1'b0);
    steps(2, "idle", NK, 1'b0, 1'b0);

    // Key0 held, key1 added, key0 released, then all released.
    rawKeys = 4'b1110;
    steps(6, "chord_press_wait", NK, 1'b0, 1'b0);
    step("chord_key0", K0, 1'b1, 1'b0);
    steps(2, "chord_held", K0, 1'b0, 1'b0);
    rawKeys = 4'b1100;
    steps(8, "chord_both", K0, 1'b0, 1'b0);
    rawKeys = 4'b1101;
    steps(8, "chord_key1_only", K0, 1'b0, 1'b0);
    rawKeys = REL;
    steps(5, "chord_release_wait", K0, 1'b0, 1'b0);
    step("chord_release_done", NK, 1'b0, 1'b0);
    steps(3, "idle", NK, 1'b0, 1'b0);

    // Reset pulse while key2 is held.
    rawKeys = 4'b1011;
    steps(6, "rst_press_wait", NK, 1'b0, 1'b0);
    step("rst_key2", K2, 1'b1, 1'b0);
    steps(2, "rst_held", K2, 1'b0, 1'b0);
    reset = 1'b1;
    step("rst_mid_press", NK, 1'b0, 1'b0);
    step("rst_hold", NK, 1'b0, 1'b0);
    reset = 1'b0;
    steps(6, "rst_redebounce", NK, 1'b0, 1'b0);
    step("rst_rekey", K2, 1'b1, 1'b0);
    step("rst_rekey_held", K2, 1'b0, 1'b0);
    rawKeys = REL;
    steps(6, "rst_release_wait", K2, 1'b0, 1'b0);
    step("rst_release_done", NK, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter CLOCK_FREQ SHALL default to 50000000 and give the clock frequency in Hz.
REQ-003 Parameter DEBOUNCE_CYCLES SHALL default to CLOCK_FREQ/50 (20 ms) and give the stable-input time in clocks; legal minimum is 1.
REQ-004 Parameter DEBOUNCE_COUNTER_WIDTH SHALL default to $clog2(DEBOUNCE_CYCLES+1) and give the counter width.
REQ-005 Port clock SHALL be an input, 1 bit wide, and be the rising-edge system clock.
REQ-006 Port reset SHALL be an input, 1 bit wide, and be the synchronous active-high reset.
REQ-007 Port rawKeys SHALL be an input, 4 bits wide, carrying asynchronous active-low push buttons (0 = pressed).
REQ-008 Port key SHALL be an output register, 4 bits wide, carrying the debounced one-hot key code (active-high), held for the full press and 0 when idle; it feeds the lock's key input.
REQ-009 Port keyPressed SHALL be an output register, 1 bit wide, pulsing high for one cycle when key becomes non-zero.
REQ-010 Port multiKey SHALL be an output register, 1 bit wide, high while more than one button is pressed in IDLE.

Function
REQ-011 rawKeys SHALL pass through a two-flop synchroniser and be inverted to active-high (syncKeys); the synchroniser flops reset to released.
REQ-012 The FSM SHALL have exactly these states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-013 IDLE: key=0; if syncKeys has exactly one bit set, the block SHALL latch it as candidate, clear the counter and go to PRESS_WAIT.
REQ-014 IDLE with two or more bits of syncKeys set SHALL set multiKey=1 and stay in IDLE; multiKey SHALL clear on the first cycle syncKeys==0.
REQ-015 PRESS_WAIT: if syncKeys!=candidate, the block SHALL clear the counter and return to IDLE with key unchanged (0).
REQ-016 PRESS_WAIT: if the counter==DEBOUNCE_CYCLES-1, the block SHALL set key<=candidate and keyPressed<=1 for one cycle, then go to HELD; otherwise it SHALL increment the counter.
REQ-017 Latency: key SHALL assert on the (DEBOUNCE_CYCLES+3)th rising edge after the first edge that samples a stable single press.
REQ-018 HELD: key SHALL remain candidate; if syncKeys!=candidate, the block SHALL clear the counter and go to RELEASE_WAIT.
REQ-019 RELEASE_WAIT: key SHALL remain candidate; syncKeys==candidate SHALL return to HELD with no new keyPressed.
REQ-020 RELEASE_WAIT: syncKeys==0 SHALL increment the counter; at counter==DEBOUNCE_CYCLES-1 the block SHALL set key<=0 and go to IDLE.
REQ-021 RELEASE_WAIT: any other non-zero syncKeys SHALL clear the counter and stay; a second key SHALL never be reported until all keys are released.
REQ-022 key SHALL always be 0 or one-hot; keyPressed SHALL fire at most once per press.
REQ-023 An illegal state SHALL force IDLE with key=0.

Reset
REQ-024 Reset SHALL force state IDLE, key=0, keyPressed=0, multiKey=0, counter=0, candidate=0, and synchroniser flops=released.
REQ-025 Reset asserted mid-press SHALL drop key to 0 on the next edge; a still-held button SHALL be re-debounced from IDLE after reset release.

Structure
REQ-026 CLOCK_FREQ SHALL live in the shared digital-lock constants package; state encodings and the debounce counter SHALL stay local.
REQ-027 The two-flop synchroniser SHALL be the single sub-module, key_synchroniser, 4 bits wide.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Press rawKeys=4'b1110 and hold: key=4'b0001 on edge 7 after the first stable sample; keyPressed high exactly that one cycle.
REQ-029 Press bouncing 1110/1111 every 2 cycles then hold stable: no key output until 4+3 edges after the last bounce; exactly one keyPressed.
REQ-030 Release with a 1-cycle re-press glitch during RELEASE_WAIT: key stays 4'b0001, with no second keyPressed, until 4 consecutive released cycles.
REQ-031 rawKeys=4'b1100 from idle: multiKey=1, key=0 throughout; release all: multiKey=0.
REQ-032 Hold key0, then also press key1, then release key0 only: key stays 4'b0001 until both are released; no keyPressed for key1.
REQ-033 Reset pulse while key=4'b0100 with the button held: key=0 the next edge, then key=4'b0100 again 7 edges after reset deasserts.
